// File: rtl/dtree_node_sequencer_if.sv
`default_nettype none
// ============================================================================
// dtree_node_sequencer_if : feature-in / class-out handshakes and node-table
// configuration port of the decision-tree node sequencer.      Rev 1.0
// ============================================================================
interface dtree_node_sequencer_if #(
  parameter int NUM_FEATURES = 21,
  parameter int FEAT_W       = 8,
  parameter int CLASS_W      = 2,
  parameter int NODE_AW      = 5,
  parameter int FIDX_W       = $clog2(NUM_FEATURES)
);
  logic                             in_valid;
  logic                             in_ready;
  logic [NUM_FEATURES*FEAT_W-1:0]   in_features;
  logic                             out_valid;
  logic                             out_ready;
  logic [CLASS_W-1:0]               out_class;
  logic                             out_err;
  logic                             cfg_we;
  logic                             cfg_ready;
  logic [NODE_AW-1:0]               cfg_addr;
  logic                             cfg_internal;
  logic [FIDX_W-1:0]                cfg_feat;
  logic [FEAT_W-1:0]                cfg_thr;
  logic [NODE_AW-1:0]               cfg_left;
  logic [NODE_AW-1:0]               cfg_right;
  logic [CLASS_W-1:0]               cfg_class;

  modport master (
    output in_valid, in_features, out_ready,
    output cfg_we, cfg_addr, cfg_internal, cfg_feat, cfg_thr, cfg_left, cfg_right, cfg_class,
    input  in_ready, out_valid, out_class, out_err, cfg_ready
  );

  modport slave (
    input  in_valid, in_features, out_ready,
    input  cfg_we, cfg_addr, cfg_internal, cfg_feat, cfg_thr, cfg_left, cfg_right, cfg_class,
    output in_ready, out_valid, out_class, out_err, cfg_ready
  );
endinterface
`default_nettype wire

// File: rtl/dtree_node_sequencer.sv
`default_nettype none
// ============================================================================
// dtree_node_sequencer : walks a programmable decision-tree node table from
// the root, one node per clock, through a single shared comparator. Rev 1.0
// ============================================================================
module dtree_node_sequencer #(
  parameter int NUM_FEATURES = 21,
  parameter int FEAT_W       = 8,
  parameter int CLASS_W      = 2,
  parameter int NODE_AW      = 5,
  parameter int FIDX_W       = $clog2(NUM_FEATURES)
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  dtree_node_sequencer_if.slave  io_bus
);
  localparam int          c_DEPTH    = 1 << NODE_AW;
  localparam logic [31:0] c_NUM_FEAT = 32'(NUM_FEATURES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EVAL = 2'd1,
    S_DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic                internal;
    logic [FIDX_W-1:0]   feat;
    logic [FEAT_W-1:0]   thr;
    logic [NODE_AW-1:0]  left;
    logic [NODE_AW-1:0]  right;
    logic [CLASS_W-1:0]  cls;
  } node_t;

  state_t               r_state;
  node_t                r_table [c_DEPTH];
  logic [FEAT_W-1:0]    r_feat  [NUM_FEATURES];
  logic [NODE_AW-1:0]   r_node;
  logic [NODE_AW-1:0]   r_step;
  logic                 r_out_valid;
  logic [CLASS_W-1:0]   r_out_class;
  logic                 r_out_err;

  logic                 w_idle;
  logic                 w_cfg_wr;
  node_t                w_node;
  logic                 w_feat_ok;
  logic [FIDX_W-1:0]    w_fidx;
  logic [FEAT_W-1:0]    w_fval;
  logic                 w_go_left;
  logic                 w_step_last;

  // Both ready outputs are held low while reset is asserted.
  assign w_idle      = rst_n && (r_state == S_IDLE);
  assign w_cfg_wr    = io_bus.cfg_we && w_idle;

  assign w_node      = r_table[r_node];
  assign w_feat_ok   = 32'(w_node.feat) < c_NUM_FEAT;
  assign w_fidx      = w_feat_ok ? w_node.feat : '0;
  assign w_fval      = r_feat[w_fidx];
  assign w_go_left   = (w_fval <= w_node.thr);
  // One more internal step would visit 2^NODE_AW nodes: the table has a cycle.
  assign w_step_last = (r_step == {NODE_AW{1'b1}});

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < c_DEPTH; i++) begin
        r_table[i] <= '0;
      end
    end else if (w_cfg_wr) begin
      r_table[io_bus.cfg_addr] <= {io_bus.cfg_internal, io_bus.cfg_feat, io_bus.cfg_thr,
                                   io_bus.cfg_left, io_bus.cfg_right, io_bus.cfg_class};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_node      <= '0;
      r_step      <= '0;
      r_out_valid <= 1'b0;
      r_out_class <= '0;
      r_out_err   <= 1'b0;
      for (int i = 0; i < NUM_FEATURES; i++) begin
        r_feat[i] <= '0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (io_bus.in_valid) begin
            for (int i = 0; i < NUM_FEATURES; i++) begin
              r_feat[i] <= io_bus.in_features[i*FEAT_W +: FEAT_W];
            end
            r_node  <= '0;
            r_step  <= '0;
            r_state <= S_EVAL;
          end
        end
        S_EVAL: begin
          if (!w_node.internal) begin
            r_out_class <= w_node.cls;
            r_out_err   <= 1'b0;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end else if (!w_feat_ok || w_step_last) begin
            r_out_class <= '0;
            r_out_err   <= 1'b1;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_node <= w_go_left ? w_node.left : w_node.right;
            r_step <= r_step + 1'b1;
          end
        end
        S_DONE: begin
          if (io_bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign io_bus.in_ready  = w_idle;
  assign io_bus.cfg_ready = w_idle;
  assign io_bus.out_valid = r_out_valid;
  assign io_bus.out_class = r_out_class;
  assign io_bus.out_err   = r_out_err;

endmodule
`default_nettype wire

// File: tb/tb_dtree_node_sequencer.sv
`default_nettype none
// tb_dtree_node_sequencer: directed literal checks plus randomized traffic,
// compared every cycle against a tree-walking reference model.
module tb_dtree_node_sequencer;
  localparam int NF    = 21;
  localparam int FW    = 8;
  localparam int CW    = 2;
  localparam int AW    = 5;
  localparam int FIW   = $clog2(NF);
  localparam int DEPTH = 1 << AW;
  localparam int VW    = NF * FW;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  dtree_node_sequencer_if #(.NUM_FEATURES(NF), .FEAT_W(FW), .CLASS_W(CW),
                            .NODE_AW(AW), .FIDX_W(FIW)) bus();

  dtree_node_sequencer #(.NUM_FEATURES(NF), .FEAT_W(FW), .CLASS_W(CW),
                         .NODE_AW(AW), .FIDX_W(FIW)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_bus (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference copy of the node table, one array per field.
  bit t_int   [DEPTH];
  int t_feat  [DEPTH];
  int t_thr   [DEPTH];
  int t_left  [DEPTH];
  int t_right [DEPTH];
  int t_cls   [DEPTH];

  // Walk the tree; d is the depth of the node that decides the outcome.
  function automatic void model_eval(input logic [VW-1:0] f, output int cls,
                                     output bit err, output int d);
    int node;
    int steps;
    int fv;
    node = 0; steps = 0; cls = 0; err = 1'b0; d = 0;
    for (int k = 0; k < 4 * DEPTH; k++) begin
      if (!t_int[node]) begin
        cls = t_cls[node]; d = steps; return;
      end
      if (t_feat[node] >= NF) begin
        err = 1'b1; d = steps; return;
      end
      fv    = int'(f[t_feat[node]*FW +: FW]);
      node  = (fv <= t_thr[node]) ? t_left[node] : t_right[node];
      steps = steps + 1;
      if (steps == DEPTH) begin
        err = 1'b1; d = DEPTH - 1; return;
      end
    end
  endfunction

  // Phases: 0 idle, 1 evaluating (m_cnt edges remaining), 2 result presented.
  int m_phase = 0;
  int m_cnt   = 0;
  int m_cls   = 0;
  bit m_err   = 1'b0;
  bit m_known = 1'b0;

  always @(negedge clk) begin
    int c;
    int d;
    bit e;
    if (m_known) begin
      check("mon_in_ready",  32'(bus.in_ready),  32'(rst_n && m_phase == 0));
      check("mon_cfg_ready", 32'(bus.cfg_ready), 32'(rst_n && m_phase == 0));
      check("mon_out_valid", 32'(bus.out_valid), 32'(m_phase == 2));
      if (m_phase == 2) begin
        check("mon_out_class", 32'(bus.out_class), 32'(m_cls));
        check("mon_out_err",   32'(bus.out_err),   32'(m_err));
      end
    end
    if (!rst_n) begin
      m_phase = 0;
      m_known = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
        t_int[i] = 1'b0; t_feat[i] = 0; t_thr[i] = 0;
        t_left[i] = 0; t_right[i] = 0; t_cls[i] = 0;
      end
    end else if (m_known) begin
      case (m_phase)
        0: begin
          if (bus.cfg_we) begin
            t_int[bus.cfg_addr]   = bus.cfg_internal;
            t_feat[bus.cfg_addr]  = int'(bus.cfg_feat);
            t_thr[bus.cfg_addr]   = int'(bus.cfg_thr);
            t_left[bus.cfg_addr]  = int'(bus.cfg_left);
            t_right[bus.cfg_addr] = int'(bus.cfg_right);
            t_cls[bus.cfg_addr]   = int'(bus.cfg_class);
          end
          if (bus.in_valid) begin
            model_eval(bus.in_features, c, e, d);
            m_cls = c; m_err = e; m_cnt = d + 1; m_phase = 1;
          end
        end
        1: begin
          m_cnt = m_cnt - 1;
          if (m_cnt == 0) m_phase = 2;
        end
        default: begin
          if (bus.out_ready) m_phase = 0;
        end
      endcase
    end
  end

  function automatic logic [VW-1:0] rand_vec();
    logic [VW-1:0] v;
    for (int i = 0; i < NF; i++) v[i*FW +: FW] = FW'($urandom);
    return v;
  endfunction

  task automatic write_node(input int a, input int intl, input int feat, input int thr,
                            input int l, input int r, input int cls);
    bus.cfg_we       = 1'b1;
    bus.cfg_addr     = AW'(a);
    bus.cfg_internal = intl[0];
    bus.cfg_feat     = FIW'(feat);
    bus.cfg_thr      = FW'(thr);
    bus.cfg_left     = AW'(l);
    bus.cfg_right    = AW'(r);
    bus.cfg_class    = CW'(cls);
    @(posedge clk); #1;
    bus.cfg_we = 1'b0;
  endtask

  task automatic start_sample(input logic [VW-1:0] f, input string name);
    int n;
    n = 0;
    bus.in_features = f;
    bus.in_valid    = 1'b1;
    while (!bus.in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.in_ready) check({name, "_accept_timeout"}, 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  // Latency counts the acceptance cycle: leaf at depth d gives d+2.
  task automatic wait_result(input int cls, input int err, input int lat, input string name);
    int n;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!bus.out_valid && n < 100);
    check({name, "_valid"},   32'(bus.out_valid), 32'd1);
    check({name, "_latency"}, 32'(n + 1),         32'(lat));
    check({name, "_class"},   32'(bus.out_class), 32'(cls));
    check({name, "_err"},     32'(bus.out_err),   32'(err));
  endtask

  task automatic run(input logic [VW-1:0] f, input int cls, input int err,
                     input int lat, input string name);
    start_sample(f, name);
    wait_result(cls, err, lat, name);
    @(posedge clk); #1;
  endtask

  logic [VW-1:0] v_zero;
  logic [VW-1:0] v;
  logic [VW-1:0] v_chain;

  initial begin
    bus.in_valid = 1'b0; bus.in_features = '0; bus.out_ready = 1'b1;
    bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_internal = 1'b0; bus.cfg_feat = '0;
    bus.cfg_thr = '0; bus.cfg_left = '0; bus.cfg_right = '0; bus.cfg_class = '0;
    v_zero = '0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_class", 32'(bus.out_class), 32'd0);
    check("rst_out_err",   32'(bus.out_err),   32'd0);
    check("rst_in_ready",  32'(bus.in_ready),  32'd0);
    check("rst_cfg_ready", 32'(bus.cfg_ready), 32'd0);
    rst_n = 1'b1;
    #1;
    check("idle_in_ready", 32'(bus.in_ready), 32'd1);

    run(v_zero, 0, 0, 2, "reset_table");

    write_node(0, 1, 20, 8'h80, 1, 2, 0);
    write_node(1, 0, 0, 0, 0, 0, 1);
    write_node(2, 0, 0, 0, 0, 0, 2);
    v = '0; v[20*FW +: FW] = 8'h80;
    run(v, 1, 0, 3, "stump_le");
    v[20*FW +: FW] = 8'h81;
    run(v, 2, 0, 3, "stump_gt");

    write_node(0, 1, 0,  8'h10, 3, 1, 0);
    write_node(3, 1, 5,  8'h20, 4, 2, 0);
    write_node(4, 1, 20, 8'h30, 5, 2, 0);
    write_node(5, 0, 0, 0, 0, 0, 3);
    v_chain = '0;
    v_chain[0*FW +: FW]  = 8'h05;
    v_chain[5*FW +: FW]  = 8'h20;
    v_chain[20*FW +: FW] = 8'h30;
    run(v_chain, 3, 0, 5, "chain");
    v = v_chain; v[5*FW +: FW] = 8'h21;
    run(v, 2, 0, 4, "chain_right");

    bus.out_ready = 1'b0;
    start_sample(v_chain, "hold");
    wait_result(3, 0, 5, "hold");
    for (int k = 0; k < 10; k++) begin
      bus.in_features  = rand_vec();
      bus.cfg_we       = k[0];
      bus.cfg_addr     = AW'(5);
      bus.cfg_internal = 1'b0;
      bus.cfg_class    = CW'(1);
      @(posedge clk); #1;
      check("hold_class",    32'(bus.out_class), 32'd3);
      check("hold_valid",    32'(bus.out_valid), 32'd1);
      check("hold_in_ready", 32'(bus.in_ready),  32'd0);
    end
    bus.cfg_we    = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    run(v_chain, 3, 0, 5, "after_hold");

    write_node(0, 1, 0, 0, 0, 0, 0);
    run(v_zero, 0, 1, DEPTH + 1, "loop_abort");
    write_node(0, 1, 25, 0, 1, 2, 0);
    run(v_zero, 0, 1, 2, "bad_feat");

    write_node(0, 1, 0, 8'h10, 3, 1, 0);
    start_sample(v_chain, "mid_reset");
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    check("post_reset_in_ready", 32'(bus.in_ready), 32'd1);
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      check("post_reset_no_valid", 32'(bus.out_valid), 32'd0);
    end
    run(v_chain, 0, 0, 2, "cleared_chain");
    run(rand_vec(), 0, 0, 2, "cleared_rand");

    for (int cyc = 0; cyc < 4000; cyc++) begin
      bus.in_valid     = ($urandom_range(0, 2) == 0);
      bus.in_features  = rand_vec();
      bus.out_ready    = ($urandom_range(0, 3) != 0);
      bus.cfg_we       = ($urandom_range(0, 2) == 0);
      bus.cfg_addr     = AW'($urandom_range(0, DEPTH - 1));
      bus.cfg_internal = ($urandom_range(0, 9) < 7);
      bus.cfg_feat     = ($urandom_range(0, 7) == 0) ? FIW'($urandom) : FIW'($urandom_range(0, NF - 1));
      bus.cfg_thr      = FW'($urandom);
      bus.cfg_left     = AW'($urandom);
      bus.cfg_right    = AW'($urandom);
      bus.cfg_class    = CW'($urandom);
      rst_n            = ($urandom_range(0, 399) != 0);
      @(posedge clk); #1;
    end

    rst_n = 1'b1; bus.in_valid = 1'b0; bus.cfg_we = 1'b0; bus.out_ready = 1'b1;
    repeat (DEPTH + 10) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
